// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: data memory, writeback select, OUT_PORT register,
// retired-instruction counter and the return (RET) redirect sequencer.
//
// Handshake: there is no valid/ready pair here. Every IDLE cycle the stage
// accepts whatever EX/MEM presents. While flush_M is high the stage is
// either launching a return (IDLE, is_ret_M=1) or issuing the redirect
// (RET_ISSUE); in RET_ISSUE every _M input is ignored, so upstream bubbles
// are harmless.
module mem_wb_stage #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en_regf_M,
  input  logic        wr_en_dmem_M,
  input  logic        rd_en_M,
  input  logic        out_port_sel_M,
  input  logic        is_ret_M,
  input  logic        mux_out_sel_M,
  input  logic [1:0]  mux_rdata_sel_M,
  input  logic [7:0]  alu_out_M,
  input  logic [7:0]  RD2_M,
  input  logic [7:0]  IN_PORT_M,
  input  logic [7:0]  mem_addr_M,
  input  logic [7:0]  mem_wd_M,
  input  logic [1:0]  rd_M,
  output logic        wr_en_regf_W,
  output logic [1:0]  rd_W,
  output logic [7:0]  wb_data_W,
  output logic [7:0]  OUT_PORT,
  output logic        pc_load,
  output logic [7:0]  ret_pc,
  output logic        flush_M,
  output logic [15:0] retired,
  output logic        dbg_state_o
);

  typedef enum logic {
    IDLE      = 1'b0,
    RET_ISSUE = 1'b1
  } state_t;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_RD2  = 2'b11;

  state_t state_q, state_d;

  logic [7:0]  mem_q [DEPTH];

  logic        wr_en_regf_q, wr_en_regf_d;
  logic [1:0]  rd_q, rd_d;
  logic [7:0]  wb_data_q, wb_data_d;
  logic [7:0]  out_port_q, out_port_d;
  logic [7:0]  ret_pc_q, ret_pc_d;
  logic [15:0] retired_q, retired_d;

  logic        idle_c;
  logic        instr_valid_c;
  logic        mem_we_c;
  logic [7:0]  mem_rdata_c;
  logic [7:0]  ld_data_c;
  logic [7:0]  wb_mux_c;
  logic [7:0]  out_mux_c;

  // Datapath decode: memory read, writeback and OUT_PORT source selection.
  always_comb begin
    idle_c        = (state_q == IDLE);
    instr_valid_c = wr_en_regf_M | wr_en_dmem_M | out_port_sel_M | is_ret_M;
    mem_we_c      = idle_c & wr_en_dmem_M;
    // Read sees the pre-edge contents, so a same-cycle store returns old data.
    mem_rdata_c   = mem_q[mem_addr_M];
    ld_data_c     = rd_en_M ? mem_rdata_c : 8'h00;

    wb_mux_c = alu_out_M;
    case (mux_rdata_sel_M)
      SEL_ALU: wb_mux_c = alu_out_M;
      SEL_MEM: wb_mux_c = ld_data_c;
      SEL_IN:  wb_mux_c = IN_PORT_M;
      SEL_RD2: wb_mux_c = RD2_M;
      default: wb_mux_c = alu_out_M;
    endcase

    out_mux_c = mux_out_sel_M ? alu_out_M : RD2_M;
  end

  // Next-state for the FSM and all architectural registers.
  always_comb begin
    state_d      = state_q;
    wr_en_regf_d = 1'b0;
    rd_d         = rd_q;
    wb_data_d    = wb_data_q;
    out_port_d   = out_port_q;
    ret_pc_d     = ret_pc_q;
    retired_d    = retired_q;

    case (state_q)
      IDLE: begin
        // A return still performs its own register/memory/port effects.
        wr_en_regf_d = wr_en_regf_M;
        rd_d         = rd_M;
        wb_data_d    = wb_mux_c;
        if (out_port_sel_M) begin
          out_port_d = out_mux_c;
        end
        if (instr_valid_c) begin
          retired_d = retired_q + 16'd1;
        end
        if (is_ret_M) begin
          ret_pc_d = mem_rdata_c;
          state_d  = RET_ISSUE;
        end
      end
      RET_ISSUE: begin
        // Redirect cycle: EX/MEM holds a bubble, nothing is accepted.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Redirect and flush outputs; gated by reset so they drop the instant
  // reset asserts, independent of the input-driven launch term.
  always_comb begin
    pc_load = 1'b0;
    flush_M = 1'b0;
    if (reset) begin
      pc_load = (state_q == RET_ISSUE);
      flush_M = (state_q == RET_ISSUE) | (idle_c & is_ret_M);
    end
  end

  // State and architectural registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_en_regf_q <= 1'b0;
      rd_q         <= 2'b00;
      wb_data_q    <= 8'h00;
      out_port_q   <= 8'h00;
      ret_pc_q     <= 8'h00;
      retired_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      wr_en_regf_q <= wr_en_regf_d;
      rd_q         <= rd_d;
      wb_data_q    <= wb_data_d;
      out_port_q   <= out_port_d;
      ret_pc_q     <= ret_pc_d;
      retired_q    <= retired_d;
    end
  end

  // Data memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_addr_M] <= mem_wd_M;
    end
  end

  assign wr_en_regf_W = wr_en_regf_q;
  assign rd_W         = rd_q;
  assign wb_data_W    = wb_data_q;
  assign OUT_PORT     = out_port_q;
  assign ret_pc       = ret_pc_q;
  assign retired      = retired_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: load/store, writeback select, OUT_PORT,
// return redirect, RET_ISSUE input masking, reset mid-return and counter wrap.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        wr_en_regf_M, wr_en_dmem_M, rd_en_M, out_port_sel_M;
  logic        is_ret_M, mux_out_sel_M;
  logic [1:0]  mux_rdata_sel_M;
  logic [7:0]  alu_out_M, RD2_M, IN_PORT_M, mem_addr_M, mem_wd_M;
  logic [1:0]  rd_M;
  logic        wr_en_regf_W;
  logic [1:0]  rd_W;
  logic [7:0]  wb_data_W, OUT_PORT, ret_pc;
  logic        pc_load, flush_M, dbg_state_o;
  logic [15:0] retired;

  int tests;
  int fails;
  logic [15:0] exp_ret;

  mem_wb_stage #(.DEPTH(256)) dut (
    .clk(clk), .reset(reset),
    .wr_en_regf_M(wr_en_regf_M), .wr_en_dmem_M(wr_en_dmem_M),
    .rd_en_M(rd_en_M), .out_port_sel_M(out_port_sel_M),
    .is_ret_M(is_ret_M), .mux_out_sel_M(mux_out_sel_M),
    .mux_rdata_sel_M(mux_rdata_sel_M),
    .alu_out_M(alu_out_M), .RD2_M(RD2_M), .IN_PORT_M(IN_PORT_M),
    .mem_addr_M(mem_addr_M), .mem_wd_M(mem_wd_M), .rd_M(rd_M),
    .wr_en_regf_W(wr_en_regf_W), .rd_W(rd_W), .wb_data_W(wb_data_W),
    .OUT_PORT(OUT_PORT), .pc_load(pc_load), .ret_pc(ret_pc),
    .flush_M(flush_M), .retired(retired), .dbg_state_o(dbg_state_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    wr_en_regf_M = 0; wr_en_dmem_M = 0; rd_en_M = 0; out_port_sel_M = 0;
    is_ret_M = 0; mux_out_sel_M = 0; mux_rdata_sel_M = 2'b00;
    alu_out_M = 0; RD2_M = 0; IN_PORT_M = 0; mem_addr_M = 0; mem_wd_M = 0;
    rd_M = 0;
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0; exp_ret = 16'd0;
    clr_inputs();
    reset = 1'b0;
    is_ret_M = 1'b1;
    #3;
    check("rst_flush", {15'd0, flush_M}, 16'd0);
    check("rst_pc_load", {15'd0, pc_load}, 16'd0);
    check("rst_wb_en", {15'd0, wr_en_regf_W}, 16'd0);
    check("rst_rd", {14'd0, rd_W}, 16'd0);
    check("rst_wb_data", {8'd0, wb_data_W}, 16'd0);
    check("rst_out", {8'd0, OUT_PORT}, 16'd0);
    check("rst_ret_pc", {8'd0, ret_pc}, 16'd0);
    check("rst_retired", retired, 16'd0);
    check("rst_state", {15'd0, dbg_state_o}, 16'd0);
    is_ret_M = 1'b0;
    #9 reset = 1'b1;
    tick();

    // Store 5A to 0x10
    wr_en_dmem_M = 1; mem_addr_M = 8'h10; mem_wd_M = 8'h5A;
    tick(); exp_ret++;
    check("store_retired", retired, exp_ret);
    check("store_no_wb", {15'd0, wr_en_regf_W}, 16'd0);

    // Load 0x10 into r2
    clr_inputs();
    rd_en_M = 1; mem_addr_M = 8'h10; mux_rdata_sel_M = 2'b01; wr_en_regf_M = 1; rd_M = 2'd2;
    tick(); exp_ret++;
    check("load_data", {8'd0, wb_data_W}, 16'h005A);
    check("load_wb_en", {15'd0, wr_en_regf_W}, 16'd1);
    check("load_rd", {14'd0, rd_W}, 16'd2);
    check("load_retired", retired, exp_ret);

    // Memory select without read enable gives zero
    rd_en_M = 0; rd_M = 2'd1;
    tick(); exp_ret++;
    check("nord_data", {8'd0, wb_data_W}, 16'h0000);
    check("nord_rd", {14'd0, rd_W}, 16'd1);

    // ALU, IN_PORT, RD2 selects
    clr_inputs();
    wr_en_regf_M = 1; alu_out_M = 8'h11; IN_PORT_M = 8'h22; RD2_M = 8'h33; rd_M = 2'd3;
    mux_rdata_sel_M = 2'b00;
    tick(); exp_ret++;
    check("sel_alu", {8'd0, wb_data_W}, 16'h0011);
    mux_rdata_sel_M = 2'b10;
    tick(); exp_ret++;
    check("sel_in", {8'd0, wb_data_W}, 16'h0022);
    mux_rdata_sel_M = 2'b11; wr_en_regf_M = 0;
    tick();
    check("sel_rd2", {8'd0, wb_data_W}, 16'h0033);
    check("sel_rd2_noen", {15'd0, wr_en_regf_W}, 16'd0);
    check("bubble_retired", retired, exp_ret);

    // OUT_PORT update and hold
    clr_inputs();
    out_port_sel_M = 1; mux_out_sel_M = 1; alu_out_M = 8'h3C; RD2_M = 8'h99;
    tick(); exp_ret++;
    check("out_alu", {8'd0, OUT_PORT}, 16'h003C);
    out_port_sel_M = 0; alu_out_M = 8'h99;
    tick();
    tick();
    check("out_hold", {8'd0, OUT_PORT}, 16'h003C);
    out_port_sel_M = 1; mux_out_sel_M = 0; RD2_M = 8'h77;
    tick(); exp_ret++;
    check("out_rd2", {8'd0, OUT_PORT}, 16'h0077);

    // Same-cycle write and read returns old data
    clr_inputs();
    wr_en_dmem_M = 1; rd_en_M = 1; mem_addr_M = 8'h10; mem_wd_M = 8'hA5;
    mux_rdata_sel_M = 2'b01; wr_en_regf_M = 1;
    tick(); exp_ret++;
    check("rw_old", {8'd0, wb_data_W}, 16'h005A);
    wr_en_dmem_M = 0;
    tick(); exp_ret++;
    check("rw_new", {8'd0, wb_data_W}, 16'h00A5);

    // Return through memory[FF]=42
    clr_inputs();
    wr_en_dmem_M = 1; mem_addr_M = 8'hFF; mem_wd_M = 8'h42;
    tick(); exp_ret++;
    clr_inputs();
    is_ret_M = 1; mem_addr_M = 8'hFF; wr_en_regf_M = 1; alu_out_M = 8'h66; rd_M = 2'd1;
    #1;
    check("ret_flush_launch", {15'd0, flush_M}, 16'd1);
    check("ret_pcload_launch", {15'd0, pc_load}, 16'd0);
    tick(); exp_ret++;
    // RET_ISSUE: drive inputs that must all be ignored
    clr_inputs();
    wr_en_dmem_M = 1; mem_addr_M = 8'hFF; mem_wd_M = 8'hEE; wr_en_regf_M = 1;
    out_port_sel_M = 1; mux_out_sel_M = 1; alu_out_M = 8'hAB; is_ret_M = 1;
    #1;
    check("issue_pc_load", {15'd0, pc_load}, 16'd1);
    check("issue_flush", {15'd0, flush_M}, 16'd1);
    check("issue_ret_pc", {8'd0, ret_pc}, 16'h0042);
    check("issue_state", {15'd0, dbg_state_o}, 16'd1);
    check("ret_own_wb_en", {15'd0, wr_en_regf_W}, 16'd1);
    check("ret_own_wb", {8'd0, wb_data_W}, 16'h0066);
    check("ret_retired", retired, exp_ret);
    tick();
    check("post_pc_load", {15'd0, pc_load}, 16'd0);
    check("post_state", {15'd0, dbg_state_o}, 16'd0);
    check("masked_wb_en", {15'd0, wr_en_regf_W}, 16'd0);
    check("masked_out", {8'd0, OUT_PORT}, 16'h0077);
    check("masked_retired", retired, exp_ret);
    clr_inputs();
    #1;
    check("post_flush", {15'd0, flush_M}, 16'd0);
    rd_en_M = 1; mem_addr_M = 8'hFF; mux_rdata_sel_M = 2'b01; wr_en_regf_M = 1;
    tick(); exp_ret++;
    check("masked_mem", {8'd0, wb_data_W}, 16'h0042);
    check("ret_pc_hold", {8'd0, ret_pc}, 16'h0042);

    // Reset asserted in RET_ISSUE
    clr_inputs();
    is_ret_M = 1; mem_addr_M = 8'h10; out_port_sel_M = 1; mux_out_sel_M = 1;
    alu_out_M = 8'h5F; wr_en_regf_M = 1;
    tick(); exp_ret++;
    clr_inputs();
    check("rr_pc_load", {15'd0, pc_load}, 16'd1);
    check("rr_ret_pc", {8'd0, ret_pc}, 16'h00A5);
    #1 reset = 1'b0;
    #1;
    check("rr_pc_load0", {15'd0, pc_load}, 16'd0);
    check("rr_flush0", {15'd0, flush_M}, 16'd0);
    check("rr_retired0", retired, 16'd0);
    check("rr_wb0", {8'd0, wb_data_W}, 16'd0);
    check("rr_out0", {8'd0, OUT_PORT}, 16'd0);
    check("rr_ret_pc0", {8'd0, ret_pc}, 16'd0);
    exp_ret = 16'd0;
    #1 reset = 1'b1;
    tick();
    check("rr_no_redirect", {15'd0, pc_load}, 16'd0);
    check("rr_idle", {15'd0, dbg_state_o}, 16'd0);
    rd_en_M = 1; mem_addr_M = 8'hFF; mux_rdata_sel_M = 2'b01; wr_en_regf_M = 1;
    tick(); exp_ret++;
    check("mem_survives_rst", {8'd0, wb_data_W}, 16'h0042);

    // Retired counter wrap
    clr_inputs();
    out_port_sel_M = 1;
    while (exp_ret != 16'hFFFF) begin
      tick(); exp_ret++;
    end
    check("retired_max", retired, 16'hFFFF);
    tick(); exp_ret++;
    check("retired_wrap", retired, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
